// File: rtl/alu_writeback_pkg.sv
// Shared decoder/micro-op types used by the execute and writeback slice.
// Holds micro_op_t and the architectural width constants.
package DecoderTypes;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  typedef struct packed {
    logic            writes_reg;
    logic [RW-1:0]   dst_reg;
    logic [XLEN-1:0] result;
  } micro_op_t;

  function automatic logic mop_writable(
    input micro_op_t m
  );
    return m.writes_reg && (m.dst_reg != '0);
  endfunction

endpackage

// File: rtl/alu_writeback_fifo.sv
// mop_fifo: synchronous micro-op FIFO with registered count.
// Push while full is accepted only together with a pop.
module mop_fifo
  import DecoderTypes::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  micro_op_t   din,
  output micro_op_t   dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  micro_op_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        (push_ok & ~pop_ok): cnt <= cnt + (AW+1)'(1);
        (pop_ok & ~push_ok): cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: filters, buffers and retires ALU results through the
// shared register-file write port, clearing scoreboard bits as it goes.
module alu_writeback
  import DecoderTypes::*;
#(
  parameter int DEPTH    = 4,
  parameter int INFLIGHT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_ready,
  input  micro_op_t       in_mop,
  output logic            stall_issue,
  output logic            wb_req,
  input  logic            wb_grant,
  output logic            rf_we,
  output logic [RW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            sb_clear,
  output logic [RW-1:0]   sb_clear_reg,
  output logic [31:0]     retired,
  output logic            overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] STALL_AT = (AW+1)'(DEPTH - INFLIGHT);

  logic            writable;
  logic            filtered;
  logic            push;
  logic            pop;
  logic            dropped;
  logic            full;
  logic            empty;
  logic [AW:0]     count;
  logic [AW:0]     count_next;
  micro_op_t       head;
  logic [1:0]      ret_inc;

  logic            wr_v;
  logic [RW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            stall_q;
  logic            ovf_q;
  logic [31:0]     ret_q;

  assign writable = in_ready & mop_writable(in_mop);
  assign filtered = in_ready & ~writable;
  assign wb_req   = ~empty;
  assign pop      = wb_req & wb_grant;
  assign push     = writable & (~full | pop);
  assign dropped  = writable & full & ~pop;
  assign ret_inc  = {1'b0, filtered} + {1'b0, pop};

  mop_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_mop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Stall looks at the occupancy the FIFO will have next cycle.
  always_comb begin
    count_next = count;
    unique case (1'b1)
      (push & ~pop): count_next = count + (AW+1)'(1);
      (pop & ~push): count_next = count - (AW+1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_v    <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      wr_v    <= pop;
      stall_q <= (count_next >= STALL_AT);
      ret_q   <= ret_q + 32'(ret_inc);
      if (pop) begin
        wr_addr <= head.dst_reg;
        wr_data <= head.result;
      end
      if (dropped) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign rf_we        = wr_v;
  assign rf_waddr     = wr_addr;
  assign rf_wdata     = wr_data;
  assign sb_clear     = wr_v;
  assign sb_clear_reg = wr_addr;
  assign stall_issue  = stall_q;
  assign retired      = ret_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: expected writes are queued at
// issue and consumed by a monitor whenever rf_we is seen.
module tb_alu_writeback;
  import DecoderTypes::*;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_ready = 1'b0;
  micro_op_t       in_mop = '0;
  logic            wb_grant = 1'b0;
  logic            stall_issue;
  logic            wb_req;
  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            sb_clear;
  logic [RW-1:0]   sb_clear_reg;
  logic [31:0]     retired;
  logic            overflow_err;

  int              checks = 0;
  int              failures = 0;
  int              writes = 0;
  int unsigned     exp_ret = 0;
  micro_op_t       expq[$];

  alu_writeback #(
    .DEPTH    (4),
    .INFLIGHT (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_ready     (in_ready),
    .in_mop       (in_mop),
    .stall_issue  (stall_issue),
    .wb_req       (wb_req),
    .wb_grant     (wb_grant),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .sb_clear     (sb_clear),
    .sb_clear_reg (sb_clear_reg),
    .retired      (retired),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic micro_op_t mk(input logic w, input int dst,
                                   input logic [63:0] res);
    micro_op_t m;
    m.writes_reg = w;
    m.dst_reg    = RW'(dst);
    m.result     = res;
    return m;
  endfunction

  task automatic send(input logic w, input int dst,
                      input logic [63:0] res, input bit drop);
    in_ready = 1'b1;
    in_mop   = mk(w, dst, res);
    if (!drop) begin
      exp_ret++;
      if (mop_writable(in_mop)) expq.push_back(in_mop);
    end
    tick();
    in_ready = 1'b0;
  endtask

  task automatic drain();
    wb_grant = 1'b1;
    for (int i = 0; i < 40 && expq.size() != 0; i++) tick();
    tick();
    tick();
    chk("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rf_we"}, 64'(rf_we), 64'd0);
    chk({tag, "_sb_clear"}, 64'(sb_clear), 64'd0);
    chk({tag, "_wb_req"}, 64'(wb_req), 64'd0);
    chk({tag, "_stall"}, 64'(stall_issue), 64'd0);
    chk({tag, "_retired"}, 64'(retired), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow_err), 64'd0);
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, "_wdata"}, rf_wdata, 64'd0);
    chk({tag, "_sbreg"}, 64'(sb_clear_reg), 64'd0);
  endtask

  always @(negedge clk) begin
    micro_op_t e;
    if (rf_we === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%0h exp=none",
                 rf_waddr, rf_wdata);
      end else begin
        e = expq.pop_front();
        chk("wb_addr", 64'(rf_waddr), 64'(e.dst_reg));
        chk("wb_data", rf_wdata, e.result);
        chk("sb_reg", 64'(sb_clear_reg), 64'(e.dst_reg));
        chk("sb_clear", 64'(sb_clear), 64'd1);
        writes++;
      end
    end
  end

  initial begin
    int base;
    logic p0v, p1v;
    int p0i, p1i, issued, delivered;

    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // single op
    wb_grant = 1'b1;
    in_ready = 1'b1;
    in_mop   = mk(1'b1, 5, 64'hAB);
    expq.push_back(in_mop);
    exp_ret++;
    @(negedge clk);
    chk("single_req_c0", 64'(wb_req), 64'd0);
    tick();
    in_ready = 1'b0;
    @(negedge clk);
    chk("single_req_c1", 64'(wb_req), 64'd1);
    chk("single_we_c1", 64'(rf_we), 64'd0);
    tick();
    @(negedge clk);
    chk("single_we_c2", 64'(rf_we), 64'd1);
    chk("single_retired", 64'(retired), 64'd1);
    tick();
    @(negedge clk);
    chk("single_we_c3", 64'(rf_we), 64'd0);
    chk("single_req_c3", 64'(wb_req), 64'd0);

    // filtered ops
    send(1'b1, 0, 64'h1, 1'b0);
    @(negedge clk);
    chk("filt_req0", 64'(wb_req), 64'd0);
    send(1'b0, 7, 64'h2, 1'b0);
    @(negedge clk);
    chk("filt_req1", 64'(wb_req), 64'd0);
    send(1'b0, 0, 64'h3, 1'b0);
    @(negedge clk);
    chk("filt_req2", 64'(wb_req), 64'd0);
    tick();
    @(negedge clk);
    chk("filt_req3", 64'(wb_req), 64'd0);
    chk("filt_retired", 64'(retired), 64'(exp_ret));

    // fill with no grant, then overflow
    wb_grant = 1'b0;
    base = writes;
    send(1'b1, 1, 64'h1111, 1'b0);
    @(negedge clk);
    chk("fill_stall1", 64'(stall_issue), 64'd0);
    send(1'b1, 2, 64'h2222, 1'b0);
    @(negedge clk);
    chk("fill_stall2", 64'(stall_issue), 64'd1);
    send(1'b1, 3, 64'h3333, 1'b0);
    send(1'b1, 4, 64'h4444, 1'b0);
    @(negedge clk);
    chk("fill_req", 64'(wb_req), 64'd1);
    chk("fill_ovf0", 64'(overflow_err), 64'd0);
    send(1'b1, 9, 64'h9999, 1'b1);
    @(negedge clk);
    chk("fill_ovf1", 64'(overflow_err), 64'd1);
    drain();
    chk("fill_writes", 64'(writes - base), 64'd4);
    chk("fill_retired", 64'(retired), 64'(exp_ret));
    chk("fill_ovf_sticky", 64'(overflow_err), 64'd1);

    // reset clears sticky overflow
    reset = 1'b1;
    expq.delete();
    exp_ret = 0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_ovf", 64'(overflow_err), 64'd0);
    chk("rst2_retired", 64'(retired), 64'd0);

    // full with simultaneous push and pop
    wb_grant = 1'b0;
    base = writes;
    send(1'b1, 10, 64'hA0, 1'b0);
    send(1'b1, 11, 64'hA1, 1'b0);
    send(1'b1, 12, 64'hA2, 1'b0);
    send(1'b1, 13, 64'hA3, 1'b0);
    @(negedge clk);
    chk("full_stall", 64'(stall_issue), 64'd1);
    wb_grant = 1'b1;
    send(1'b1, 14, 64'hA4, 1'b0);
    wb_grant = 1'b0;
    @(negedge clk);
    chk("pp_ovf", 64'(overflow_err), 64'd0);
    chk("pp_req", 64'(wb_req), 64'd1);
    chk("pp_stall", 64'(stall_issue), 64'd1);
    tick();
    @(negedge clk);
    chk("pp_stall_hold", 64'(stall_issue), 64'd1);
    drain();
    chk("pp_writes", 64'(writes - base), 64'd5);
    chk("pp_retired", 64'(retired), 64'(exp_ret));

    // toggled grant with a stall-honouring stream
    base = writes;
    p0v = 1'b0; p1v = 1'b0; p0i = 0; p1i = 0;
    issued = 0; delivered = 0;
    wb_grant = 1'b0;
    for (int c = 0; c < 300 && delivered < 16; c++) begin
      in_ready = p1v;
      if (p1v) begin
        in_mop = mk((p1i % 4) != 3, (p1i % 31) + 1,
                    64'hC0DE_0000 + 64'(p1i));
        exp_ret++;
        if (mop_writable(in_mop)) expq.push_back(in_mop);
        delivered++;
      end
      p1v = p0v;
      p1i = p0i;
      p0v = (!stall_issue && issued < 16);
      if (p0v) begin
        p0i = issued;
        issued++;
      end
      wb_grant = ~wb_grant;
      tick();
    end
    in_ready = 1'b0;
    chk("tog_delivered", 64'(delivered), 64'd16);
    drain();
    chk("tog_writes", 64'(writes - base), 64'd12);
    chk("tog_ovf", 64'(overflow_err), 64'd0);
    chk("tog_retired", 64'(retired), 64'(exp_ret));

    // reset with 3 queued and a write stage in flight
    wb_grant = 1'b0;
    send(1'b1, 21, 64'hD1, 1'b0);
    send(1'b1, 22, 64'hD2, 1'b0);
    send(1'b1, 23, 64'hD3, 1'b0);
    send(1'b1, 24, 64'hD4, 1'b0);
    wb_grant = 1'b1;
    tick();
    reset = 1'b1;
    @(negedge clk);
    #1;
    expq.delete();
    exp_ret = 0;
    tick();
    @(negedge clk);
    chk_all_zero("midrst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("midrst_nowe", 64'(rf_we), 64'd0);
    end
    base = writes;
    send(1'b1, 3, 64'h33, 1'b0);
    drain();
    chk("post_rst_write", 64'(writes - base), 64'd1);
    chk("post_rst_retired", 64'(retired), 64'(exp_ret));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
